uart_boot_loader_ctrl: RTL and testbench

//  Sequences program download: takes bytes from the UART receiver, frames them as
//  [LEN][PAYLOAD x LEN][XOR-CHK], writes PAYLOAD into instruction memory, and holds
//  the CPU until a valid image is loaded. Sits between the UART RX/FIFO output and
//  the instruction-memory write port; drives CPU hold/reset.

---
 rtl/uart_boot_loader_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_boot_loader_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_ctrl.sv
// uart_boot_loader_ctrl
//   Sequences a program download from the UART receiver. Bytes are framed as
//   [LEN][PAYLOAD x LEN][XOR-CHK]. Payload bytes go to the instruction memory.
//   The CPU is held until a complete image with a good checksum has been loaded.
//
// Ports
//   Clk, Reset       system clock; asynchronous active-high reset
//   Load             download switch (asynchronous level); a rising edge starts a session
//   rx_valid/rx_data one-cycle received-byte strobe and its data
//   rx_fe            framing error, sampled only together with rx_valid
//   mem_we/addr/wdata instruction-memory write port (one clock after the byte)
//   cpu_hold         1 = CPU stalled (every state except DONE)
//   cpu_rst          one-cycle CPU reset pulse on entry to DONE
//   busy, done       session in progress / image loaded
//   err_code         0 none, 1 bad LEN, 2 checksum, 3 framing, 4 timeout
//   bytes_loaded     payload bytes written in this session
module uart_boot_loader_ctrl #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 104120
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Load,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_fe,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          cpu_hold,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err_code,
  output logic [AW:0]   bytes_loaded
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CHK     = 3'd2,
    ERR_FRAME   = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_t;

  state_t          state_q, state_d;
  err_t            err_q, err_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [7:0]      chk_q, chk_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            load_meta_q, load_sync_q, load_prev_q;
  logic            start;

  // Load is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      load_meta_q <= 1'b0;
      load_sync_q <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      load_meta_q <= Load;
      load_sync_q <= load_meta_q;
      load_prev_q <= load_sync_q;
    end
  end

  assign start = load_sync_q & ~load_prev_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_NONE;
      len_q     <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      timer_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      timer_q   <= timer_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (start) begin
      // start has priority over any byte arriving in the same cycle
      state_d = S_LEN;
      err_d   = ERR_NONE;
      cnt_d   = '0;
      chk_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        S_LEN, S_DATA, S_CHK: begin
          timer_d = timer_q + 1'b1;
          if (rx_valid) begin
            // a byte in the expiry cycle still counts, so test rx_valid first
            timer_d = '0;
            if (rx_fe) begin
              state_d = S_ERROR;
              err_d   = ERR_FRAME;
            end else begin
              case (state_q)
                S_LEN: begin
                  if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) begin
                    state_d = S_ERROR;
                    err_d   = ERR_LEN;
                  end else begin
                    len_d   = rx_data[AW:0];
                    state_d = S_DATA;
                  end
                end
                S_DATA: begin
                  // payload index doubles as the write address; LEN <= DEPTH
                  // keeps it inside the memory without wrapping
                  we_d    = 1'b1;
                  addr_d  = cnt_q[AW-1:0];
                  wdata_d = rx_data;
                  chk_d   = chk_q ^ rx_data;
                  cnt_d   = cnt_q + 1'b1;
                  if (cnt_d == len_q) begin
                    state_d = S_CHK;
                  end
                end
                default: begin
                  if (rx_data == chk_q) begin
                    state_d = S_DONE;
                  end else begin
                    state_d = S_ERROR;
                    err_d   = ERR_CHK;
                  end
                end
              endcase
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end

    cpu_rst_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign busy         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign err_code     = err_q;
  assign bytes_loaded = cnt_q;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Testbench for uart_boot_loader_ctrl: table-driven frames plus hand-written
// timeout, reset and restart sequences; memory writes checked by a scoreboard.
module tb_uart_boot_loader_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned TMO   = 40;

  logic          Clk, Reset, Load;
  logic          rx_valid, rx_fe;
  logic [7:0]    rx_data;
  logic          mem_we, cpu_hold, cpu_rst, busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [2:0]    err_code;
  logic [AW:0]   bytes_loaded;

  uart_boot_loader_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_fe(rx_fe),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err_code(err_code), .bytes_loaded(bytes_loaded)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int rst_cnt = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;
  wr_t exp_q[$];

  // Frame vectors: bytes left-aligned (byte 0 in the top 8 bits); fe_at=15 means none
  typedef struct packed {
    logic [39:0] bytes;
    logic [3:0]  n;
    logic [3:0]  fe_at;
    logic [2:0]  err;
    logic        dn;
    logic [5:0]  bl;
  } vec_t;
  vec_t vecs[8];

  logic [7:0] fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write the DUT makes must match the next expected one
  always @(negedge Clk) begin
    if (cpu_rst === 1'b1) rst_cnt++;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Called and returns at posedge+1; the byte is captured on the next edge
  task automatic send_byte(input logic [7:0] d, input logic fe, input int gap);
    rx_valid = 1'b1; rx_data = d; rx_fe = fe;
    tick(1);
    rx_valid = 1'b0; rx_fe = 1'b0; rx_data = 8'h00;
    tick(gap);
  endtask

  // Small protocol model decides which bytes should reach memory
  task automatic send_frame(input logic [7:0] fb[$], input int fe_at, input int gap);
    int ms, mlen, cnt;
    logic fe;
    ms = 0; mlen = 0; cnt = 0;
    for (int i = 0; i < fb.size(); i++) begin
      fe = (i == fe_at);
      case (ms)
        0: begin
          if (fe || fb[i] == 8'd0 || 32'(fb[i]) > DEPTH) ms = 3;
          else begin mlen = int'(fb[i]); ms = 1; end
        end
        1: begin
          if (fe) ms = 3;
          else begin
            exp_q.push_back('{a: cnt[AW-1:0], d: fb[i]});
            cnt++;
            if (cnt == mlen) ms = 2;
          end
        end
        2: ms = 3;
        default: ;
      endcase
      send_byte(fb[i], fe, gap);
    end
  endtask

  task automatic do_load(input string name);
    int k;
    Load = 1'b0;
    tick(3);
    Load = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 8) begin
      tick(1);
      k++;
    end
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_latency_ok"}, 32'(k >= 2 && k <= 3), 32'd1);
    Load = 1'b0;
  endtask

  task automatic check_end(input string name, input logic [2:0] err, input logic dn,
                           input logic [5:0] bl, input int rst_base);
    tick(3);
    check({name, "_err_code"}, 32'(err_code), 32'(err));
    check({name, "_done"}, 32'(done), 32'(dn));
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!dn));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_bytes_loaded"}, 32'(bytes_loaded), 32'(bl));
    check({name, "_cpu_rst_pulses"}, 32'(rst_cnt - rst_base), dn ? 32'd1 : 32'd0);
    check({name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_mem_we"}, 32'(mem_we), 32'd0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err_code"}, 32'(err_code), 32'd0);
    check({name, "_bytes_loaded"}, 32'(bytes_loaded), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rb;
    logic [7:0] x;

    vecs[0] = '{bytes: 40'h03A1B2C3D0, n: 4'd5, fe_at: 4'd15, err: 3'd0, dn: 1'b1, bl: 6'd3};
    vecs[1] = '{bytes: 40'h0021000000, n: 4'd2, fe_at: 4'd15, err: 3'd1, dn: 1'b0, bl: 6'd0};
    vecs[2] = '{bytes: 40'h2100000000, n: 4'd1, fe_at: 4'd15, err: 3'd1, dn: 1'b0, bl: 6'd0};
    vecs[3] = '{bytes: 40'h0211220000, n: 4'd4, fe_at: 4'd15, err: 3'd2, dn: 1'b0, bl: 6'd2};
    vecs[4] = '{bytes: 40'h0310200000, n: 4'd3, fe_at: 4'd2,  err: 3'd3, dn: 1'b0, bl: 6'd1};
    vecs[5] = '{bytes: 40'h015A5A0000, n: 4'd3, fe_at: 4'd15, err: 3'd0, dn: 1'b1, bl: 6'd1};
    vecs[6] = '{bytes: 40'h7700000000, n: 4'd1, fe_at: 4'd0,  err: 3'd3, dn: 1'b0, bl: 6'd0};
    vecs[7] = '{bytes: 40'h01AAAA0000, n: 4'd3, fe_at: 4'd2,  err: 3'd3, dn: 1'b0, bl: 6'd1};

    Reset = 1'b1; Load = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_fe = 1'b0;
    tick(2);
    check_reset_vals("reset");
    Reset = 1'b0;
    tick(2);

    for (int v = 0; v < 8; v++) begin
      do_load($sformatf("vec%0d_load", v));
      rb = rst_cnt;
      fq.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) fq.push_back(vecs[v].bytes[39-8*i -: 8]);
      send_frame(fq, (vecs[v].fe_at == 4'd15) ? -1 : int'(vecs[v].fe_at), 2);
      check_end($sformatf("vec%0d", v), vecs[v].err, vecs[v].dn, vecs[v].bl, rb);
    end

    // Largest legal frame: LEN = DEPTH, last write lands on address DEPTH-1
    do_load("maxlen_load");
    rb = rst_cnt;
    fq.delete();
    fq.push_back(8'(DEPTH));
    x = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fq.push_back(8'(i * 7 + 1));
      x = x ^ 8'(i * 7 + 1);
    end
    fq.push_back(x);
    send_frame(fq, -1, 1);
    check_end("maxlen", 3'd0, 1'b1, 6'(DEPTH), rb);

    // Silence after a payload byte: still busy one clock before expiry, error after
    do_load("tmo_load");
    rb = rst_cnt;
    fq.delete(); fq.push_back(8'h02); fq.push_back(8'h11);
    send_frame(fq, -1, 0);
    tick(int'(TMO) - 1);
    check("tmo_before_busy", 32'(busy), 32'd1);
    check("tmo_before_err", 32'(err_code), 32'd0);
    tick(1);
    check("tmo_err_code", 32'(err_code), 32'd4);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_bytes_loaded", 32'(bytes_loaded), 32'd1);
    check("tmo_cpu_hold", 32'(cpu_hold), 32'd1);

    // Byte arriving in the expiry cycle is accepted
    do_load("tmo_edge_load");
    rb = rst_cnt;
    fq.delete(); fq.push_back(8'h02); fq.push_back(8'h11);
    send_frame(fq, -1, 0);
    tick(int'(TMO) - 1);
    exp_q.push_back('{a: 5'd1, d: 8'h22});
    send_byte(8'h22, 1'b0, 0);
    check("tmo_edge_busy", 32'(busy), 32'd1);
    check("tmo_edge_err", 32'(err_code), 32'd0);
    check("tmo_edge_bytes", 32'(bytes_loaded), 32'd2);
    send_byte(8'h33, 1'b0, 0);
    check_end("tmo_edge", 3'd0, 1'b1, 6'd2, rb);

    // Asynchronous reset in the middle of the payload
    do_load("rst_mid_load");
    fq.delete(); fq.push_back(8'h04); fq.push_back(8'hAA); fq.push_back(8'hBB);
    send_frame(fq, -1, 2);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    check("rst_mid_writes_drained", 32'(exp_q.size()), 32'd0);
    tick(1);
    Reset = 1'b0;
    tick(2);

    // Reach DONE, then a new Load edge re-holds the CPU and starts a fresh session
    do_load("done_a_load");
    rb = rst_cnt;
    fq.delete(); fq.push_back(8'h01); fq.push_back(8'h5A); fq.push_back(8'h5A);
    send_frame(fq, -1, 2);
    check_end("done_a", 3'd0, 1'b1, 6'd1, rb);
    do_load("restart_load");
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_bytes_cleared", 32'(bytes_loaded), 32'd0);
    rb = rst_cnt;
    fq.delete();
    fq.push_back(8'h02); fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    send_frame(fq, -1, 2);
    check_end("restart", 3'd0, 1'b1, 6'd2, rb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
